// File: rtl/stream_demux_reg_pkg.sv
// Shared constants and helpers for the registered stream demultiplexer.
// The package exposes the default widths and the select range test.
package stream_demux_pkg;

  localparam int unsigned W_DEFAULT     = 8;
  localparam int unsigned N_OUT_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT = 8;

  // Selects at or above the output count address no slot and are dropped.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return (sel < n);
  endfunction

endpackage

// File: rtl/stream_demux_reg_if.sv
// Producer-side input stream plus N_OUT consumer-side output streams.
// The master modport is the environment and the slave modport is the demux.
interface stream_demux_reg_if #(
  parameter int unsigned N_OUT = stream_demux_pkg::N_OUT_DEFAULT,
  parameter int unsigned W     = stream_demux_pkg::W_DEFAULT,
  parameter int unsigned SEL_W = $clog2(N_OUT) + 1
);

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic [SEL_W-1:0]     in_sel;
  logic [N_OUT-1:0]     out_valid;
  logic [N_OUT-1:0]     out_ready;
  logic [N_OUT*W-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_demux_reg_slot.sv
// One-entry holding register for a single demux output stream.
// A slot can take a new word when it is empty or is draining this cycle.
module demux_slot #(
  parameter int unsigned W = stream_demux_pkg::W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fill,
  input  logic [W-1:0] fill_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         can_accept
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    if (fill) begin
      valid_d = 1'b1;
      data_d  = fill_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // NOTE: the data register is reset as well because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign can_accept = ~valid_q | out_ready;

endmodule

// File: rtl/stream_demux_reg.sv
// Registered 1-to-N_OUT stream demultiplexer with a saturating drop counter.
// Out-of-range selects are always accepted and counted instead of routed.
module stream_demux_reg
  import stream_demux_pkg::*;
#(
  parameter int unsigned N_OUT = N_OUT_DEFAULT,
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned SEL_W = $clog2(N_OUT) + 1,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  stream_demux_reg_if.slave bus,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N_OUT-1:0]   can_accept;
  logic [N_OUT-1:0]   fill;
  logic [N_OUT-1:0]   slot_valid;
  logic [N_OUT*W-1:0] slot_data;
  logic               sel_ok;
  logic               sel_ready;
  logic               in_ready;
  logic               accept;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  // Only the selected slot's can_accept reaches in_ready, giving head-of-line blocking.
  always_comb begin
    sel_ok     = sel_in_range(32'(bus.in_sel), N_OUT);
    sel_ready  = 1'b0;
    fill       = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.in_sel == SEL_W'(k)) sel_ready = can_accept[k];
    end
    in_ready   = rst & (~sel_ok | sel_ready);
    accept     = bus.in_valid & in_ready;
    for (int k = 0; k < N_OUT; k++) begin
      fill[k] = accept & sel_ok & (bus.in_sel == SEL_W'(k));
    end
    drop_cnt_d = drop_cnt_q;
    if (accept && !sel_ok && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .fill       (fill[k]),
      .fill_data  (bus.in_data),
      .out_valid  (slot_valid[k]),
      .out_ready  (bus.out_ready[k]),
      .out_data   (slot_data[k*W +: W]),
      .can_accept (can_accept[k])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = slot_valid;
  assign bus.out_data  = slot_data;
  assign drop_cnt      = drop_cnt_q;

endmodule
